// File: rtl/pipe_hazard_ctrl_pkg.sv
// Common types and helpers for the hazard controller.
`include "pipe_defines.sv"
package pipe_hazard_ctrl_pkg;
  localparam logic [1:0] MODE_NORMAL = `Normal;
  localparam logic [1:0] MODE_STALL  = `Stall;
  localparam logic [1:0] MODE_FLUSH  = `Flush;

  typedef logic [`GPR_ADDR_SPACE] gpr_addr_t;

  // Source operand reads the register the EXE instruction is about to produce.
  function automatic logic src_hit(input logic re, input gpr_addr_t rs, input gpr_addr_t rd);
    return re & (rs == rd);
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: stage hazard inputs in, per-stage modes and perf counters out.
`include "pipe_defines.sv"
interface pipe_hazard_ctrl_if;
  logic [`GPR_ADDR_SPACE] id_rs1_addr_i, id_rs2_addr_i;
  logic                   id_rs1_re_i, id_rs2_re_i;
  logic [`GPR_ADDR_SPACE] ex_rd_addr_i;
  logic                   ex_rd_we_i, ex_mem_re_i;
  logic                   ex_branch_taken_i;
  logic                   ex_div_start_i;
  logic                   mem_req_i, mem_ready_i;
  logic [1:0]             pc_mode_o, if_id_mode_o, id_exe_mode_o, exe_mem_mode_o, mem_wb_mode_o;
  logic [31:0]            stall_cnt_o, flush_cnt_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
           ex_rd_addr_i, ex_rd_we_i, ex_mem_re_i, ex_branch_taken_i, ex_div_start_i,
           mem_req_i, mem_ready_i,
    input  pc_mode_o, if_id_mode_o, id_exe_mode_o, exe_mem_mode_o, mem_wb_mode_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
           ex_rd_addr_i, ex_rd_we_i, ex_mem_re_i, ex_branch_taken_i, ex_div_start_i,
           mem_req_i, mem_ready_i,
    output pc_mode_o, if_id_mode_o, id_exe_mode_o, exe_mem_mode_o, mem_wb_mode_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_defines.sv
// Shared pipeline defines: stage-register modes and GPR address range.
// Every pipeline register and the hazard controller include this header.
`ifndef PIPE_DEFINES_SV
`define PIPE_DEFINES_SV
`define Normal 2'b00
`define Stall  2'b01
`define Flush  2'b10
`define GPR_ADDR_SPACE 4:0
`endif

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage Normal/Stall/Flush from memory wait,
// multi-cycle EXE ops, taken branches and load-use; plus stall/flush counters.
`include "pipe_defines.sv"
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int unsigned CW = $clog2(DIV_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 2);

  typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_stall, load_use, br_flush;
  logic [1:0]  pc_mode, if_id_mode, id_exe_mode, exe_mem_mode, mem_wb_mode;

  assign mem_stall = hz.mem_req_i & ~hz.mem_ready_i;
  assign load_use  = hz.ex_mem_re_i & hz.ex_rd_we_i & (hz.ex_rd_addr_i != '0) &
                     (src_hit(hz.id_rs1_re_i, hz.id_rs1_addr_i, hz.ex_rd_addr_i) |
                      src_hit(hz.id_rs2_re_i, hz.id_rs2_addr_i, hz.ex_rd_addr_i));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    br_flush     = 1'b0;
    pc_mode      = MODE_NORMAL;
    if_id_mode   = MODE_NORMAL;
    id_exe_mode  = MODE_NORMAL;
    exe_mem_mode = MODE_NORMAL;
    mem_wb_mode  = MODE_NORMAL;
    if (mem_stall) begin
      // Whole front of the pipe freezes; a bubble drains into WB. FSM frozen too.
      pc_mode      = MODE_STALL;
      if_id_mode   = MODE_STALL;
      id_exe_mode  = MODE_STALL;
      exe_mem_mode = MODE_STALL;
      mem_wb_mode  = MODE_FLUSH;
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        pc_mode      = MODE_STALL;
        if_id_mode   = MODE_STALL;
        id_exe_mode  = MODE_STALL;
        exe_mem_mode = MODE_FLUSH;
        cnt_d        = cnt_q - CW'(1);
      end else begin
        state_d = RUN;
      end
    end else if (hz.ex_branch_taken_i) begin
      if_id_mode  = MODE_FLUSH;
      id_exe_mode = MODE_FLUSH;
      br_flush    = 1'b1;
    end else if (hz.ex_div_start_i) begin
      // Start cycle plus DIV_LAT-2 countdown plus the completion cycle = DIV_LAT.
      pc_mode      = MODE_STALL;
      if_id_mode   = MODE_STALL;
      id_exe_mode  = MODE_STALL;
      exe_mem_mode = MODE_FLUSH;
      state_d      = BUSY;
      cnt_d        = CNT_LOAD;
    end else if (load_use) begin
      pc_mode     = MODE_STALL;
      if_id_mode  = MODE_STALL;
      id_exe_mode = MODE_FLUSH;
    end
    if (!rst_ni) begin
      pc_mode      = MODE_FLUSH;
      if_id_mode   = MODE_FLUSH;
      id_exe_mode  = MODE_FLUSH;
      exe_mem_mode = MODE_FLUSH;
      mem_wb_mode  = MODE_FLUSH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_mode_o      = pc_mode;
  assign hz.if_id_mode_o   = if_id_mode;
  assign hz.id_exe_mode_o  = id_exe_mode;
  assign hz.exe_mem_mode_o = exe_mem_mode;
  assign hz.mem_wb_mode_o  = mem_wb_mode;

  sat_counter u_stall_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (pc_mode == MODE_STALL),
    .cnt_o (hz.stall_cnt_o)
  );

  sat_counter u_flush_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (br_flush),
    .cnt_o (hz.flush_cnt_o)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// compared against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int unsigned DIV_LAT = 4;
  localparam logic [1:0] N = MODE_NORMAL, S = MODE_STALL, F = MODE_FLUSH;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT)) dut (
    .clk_i (gclk),
    .rst_ni(grst_n),
    .hz    (hz.slave)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       re1, re2;
    logic [4:0] rd;
    logic       we, mre, br, div, mreq, mrdy;
  } stim_t;

  int n_chk = 0, n_pass = 0;
  int busy_left = 0;
  logic [31:0] m_stall = '0, m_flush = '0;

  wire [9:0] modes_obs = {hz.pc_mode_o, hz.if_id_mode_o, hz.id_exe_mode_o,
                          hz.exe_mem_mode_o, hz.mem_wb_mode_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, want);
  endtask

  task automatic drive(input stim_t s);
    hz.id_rs1_addr_i     = s.rs1;
    hz.id_rs2_addr_i     = s.rs2;
    hz.id_rs1_re_i       = s.re1;
    hz.id_rs2_re_i       = s.re2;
    hz.ex_rd_addr_i      = s.rd;
    hz.ex_rd_we_i        = s.we;
    hz.ex_mem_re_i       = s.mre;
    hz.ex_branch_taken_i = s.br;
    hz.ex_div_start_i    = s.div;
    hz.mem_req_i         = s.mreq;
    hz.mem_ready_i       = s.mrdy;
  endtask

  // Reference: busy_left = EXE cycles still owed to the running multi-cycle op.
  task automatic ref_eval(input stim_t s, output logic [9:0] m, output int nb,
                          output bit st, output bit fl);
    bit hit = 0;
    logic [4:0] src [2];
    bit en [2];
    src[0] = s.rs1; src[1] = s.rs2; en[0] = s.re1; en[1] = s.re2;
    if (s.mre && s.we && s.rd != 5'd0)
      for (int k = 0; k < 2; k++) if (en[k] && src[k] == s.rd) hit = 1;
    nb = busy_left;
    fl = 0;
    if (s.mreq && !s.mrdy)    m = {S, S, S, S, F};
    else if (busy_left > 1)   begin m = {S, S, S, F, N}; nb = busy_left - 1; end
    else if (busy_left == 1)  begin m = {N, N, N, N, N}; nb = 0; end
    else if (s.br)            begin m = {N, F, F, N, N}; fl = 1; end
    else if (s.div)           begin m = {S, S, S, F, N}; nb = DIV_LAT - 1; end
    else if (hit)             m = {S, S, F, N, N};
    else                      m = {N, N, N, N, N};
    st = (m[9:8] == S);
  endtask

  task automatic cyc(input string tag, input stim_t s);
    logic [9:0] m;
    int nb;
    bit st, fl;
    @(negedge gclk);
    drive(s);
    #1;
    ref_eval(s, m, nb, st, fl);
    chk({tag, ".modes"}, 32'(modes_obs), 32'(m));
    chk({tag, ".stall_cnt"}, hz.stall_cnt_o, m_stall);
    chk({tag, ".flush_cnt"}, hz.flush_cnt_o, m_flush);
    @(posedge gclk);
    busy_left = nb;
    if (st && m_stall != '1) m_stall++;
    if (fl && m_flush != '1) m_flush++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge gclk);
    #2;
    grst_n = 1'b0;
    #1;
    chk({tag, ".modes"}, 32'(modes_obs), 32'({F, F, F, F, F}));
    chk({tag, ".stall_cnt"}, hz.stall_cnt_o, 32'd0);
    chk({tag, ".flush_cnt"}, hz.flush_cnt_o, 32'd0);
    drive('0);
    @(negedge gclk);
    grst_n = 1'b1;
    busy_left = 0;
    m_stall = '0;
    m_flush = '0;
  endtask

  initial begin
    stim_t s, idle;
    idle = '0;
    drive(idle);
    #2;
    chk("rst.modes", 32'(modes_obs), 32'({F, F, F, F, F}));
    chk("rst.stall_cnt", hz.stall_cnt_o, 32'd0);
    chk("rst.flush_cnt", hz.flush_cnt_o, 32'd0);
    @(negedge gclk);
    grst_n = 1'b1;
    cyc("idle", idle);

    // Load-use on x5, then same pattern targeting x0
    s = idle; s.mre = 1; s.we = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.re1 = 1;
    cyc("lu", s);
    cyc("lu_after", idle);
    s.rd = 5'd0; s.rs1 = 5'd0;
    cyc("lu_x0", s);
    s = idle; s.mre = 1; s.we = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.re2 = 1;
    cyc("lu_rs2", s);

    // Taken branch
    s = idle; s.br = 1;
    cyc("br", s);
    cyc("br_after", idle);

    // Multi-cycle op held until release
    s = idle; s.div = 1;
    for (int i = 0; i < DIV_LAT; i++) cyc("div", s);
    cyc("div_after", idle);

    // Memory wait in the middle of a multi-cycle op
    s = idle; s.div = 1;
    cyc("divm", s);
    cyc("divm", s);
    s.mreq = 1; s.mrdy = 0;
    for (int i = 0; i < 3; i++) cyc("divm_wait", s);
    s.mreq = 0;
    for (int i = 0; i < DIV_LAT - 2; i++) cyc("divm_tail", s);
    cyc("divm_after", idle);

    // Branch during memory wait, then ready rises
    s = idle; s.br = 1; s.mreq = 1; s.mrdy = 0;
    cyc("brm_wait", s);
    cyc("brm_wait", s);
    s.mrdy = 1;
    cyc("brm_go", s);
    cyc("brm_after", idle);

    // Branch and div start together: branch wins, no busy phase
    s = idle; s.br = 1; s.div = 1;
    cyc("br_div", s);
    cyc("br_div_after", idle);

    // Reset mid-op
    s = idle; s.div = 1;
    cyc("divr", s);
    cyc("divr", s);
    do_reset("rst_busy");
    cyc("rst_idle", idle);
    cyc("rst_idle2", idle);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.re1  = 1'($urandom);
      s.re2  = 1'($urandom);
      s.we   = 1'($urandom);
      s.mre  = 1'($urandom);
      s.br   = ($urandom % 6) == 0;
      s.div  = ($urandom % 8) == 0;
      s.mreq = 1'($urandom);
      s.mrdy = ($urandom % 3) != 0;
      cyc("rnd", s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
